// File: rtl/cipher_mmio_ctrl.sv
// Memory-mapped front end for a block-cipher core: key/data registers, a load sequencer
// with watchdog, and a FIFO of whole result blocks with level interrupt.
module cipher_mmio_ctrl #(
   parameter int unsigned KEY_WORDS  = 4,
   parameter int unsigned DATA_WORDS = 4,
   parameter logic [31:0] BASE       = 32'h0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                      wb_clk,
   input  logic                      reset,
   input  logic                      request,
   input  logic                      write,
   input  logic [31:0]               address,
   input  logic [3:0]                byte_sel,
   input  logic [31:0]               data_from_bus,
   output logic [31:0]               data_to_bus,
   output logic                      done,
   output logic                      err,
   output logic [32*KEY_WORDS-1:0]   core_kin,
   output logic [32*DATA_WORDS-1:0]  core_din,
   output logic                      core_encdec,
   output logic                      core_krdy,
   output logic                      core_drdy,
   input  logic                      core_bsy,
   input  logic                      core_kvld,
   input  logic                      core_dvld,
   input  logic [32*DATA_WORDS-1:0]  core_dout,
   output logic                      irq
);

   localparam int unsigned OFF_DIN  = KEY_WORDS;
   localparam int unsigned OFF_CTRL = KEY_WORDS + DATA_WORDS;
   localparam int unsigned OFF_STAT = OFF_CTRL + 1;
   localparam int unsigned OFF_DOUT = OFF_CTRL + 2;
   localparam int unsigned OFF_LAST = OFF_DOUT + DATA_WORDS - 1;
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned CW       = AW + 1;
   localparam int unsigned WDW      = $clog2(TIMEOUT + 1);
   localparam int unsigned BW       = 32 * DATA_WORDS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_KEY,
      S_WAIT_KEY,
      S_LOAD_DATA,
      S_WAIT_DATA,
      S_PUSH
   } state_t;

   state_t         state_q;
   logic           krdy_q, drdy_q;
   logic           key_dirty_q;
   logic           terr_q;
   logic [WDW-1:0] wdog_q;
   logic [BW-1:0]  res_q;

   logic [31:0]    key_q [KEY_WORDS];
   logic [31:0]    din_q [DATA_WORDS];
   logic           encdec_q, irq_en_q;

   logic [BW-1:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [BW-1:0]  head;

   logic [31:0]    off, wmask, rd_word;
   logic           busy, fifo_full, fifo_empty;
   logic           misaligned, out_of_range, ro_write, start_bit;
   logic           acc_ok, wr_acc, rd_acc, start_acc, clr_acc, key_wr, pop, push;

   // ---------------- address decode / access qualification ----------------
   assign off          = (address - BASE) >> 2;
   assign busy         = (state_q != S_IDLE);
   assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty   = (count_q == '0);
   assign misaligned   = (address[1:0] != 2'b00);
   assign out_of_range = (off > OFF_LAST);
   assign ro_write     = write && (off >= OFF_STAT);
   assign start_bit    = write && (off == OFF_CTRL) && byte_sel[0] && data_from_bus[0];

   assign done = request;
   assign err  = request && (misaligned || out_of_range || ro_write ||
                             (start_bit && (busy || fifo_full)));

   assign acc_ok    = request && !err;
   assign wr_acc    = acc_ok && write;
   assign rd_acc    = acc_ok && !write;
   assign start_acc = acc_ok && start_bit;
   assign clr_acc   = wr_acc && (off == OFF_CTRL) && byte_sel[0] && data_from_bus[3];
   assign key_wr    = wr_acc && (off < OFF_DIN);
   assign pop       = rd_acc && (off == OFF_LAST) && byte_sel[3] && !fifo_empty;
   assign push      = (state_q == S_PUSH);

   assign wmask = {{8{byte_sel[3]}}, {8{byte_sel[2]}}, {8{byte_sel[1]}}, {8{byte_sel[0]}}};
   assign head  = fifo_mem[rd_ptr_q];

   // ---------------- read mux ----------------
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < KEY_WORDS; i++)
         if (off == i) rd_word = key_q[i];
      for (int unsigned i = 0; i < DATA_WORDS; i++)
         if (off == OFF_DIN + i) rd_word = din_q[i];
      if (off == OFF_CTRL) rd_word = {28'd0, 1'b0, irq_en_q, encdec_q, 1'b0};
      if (off == OFF_STAT) rd_word = {16'd0, 8'(count_q), 5'd0, fifo_full, terr_q, busy};
      for (int unsigned i = 0; i < DATA_WORDS; i++)
         if ((off == OFF_DOUT + i) && !fifo_empty) rd_word = head[32*i +: 32];
   end

   assign data_to_bus = rd_acc ? (rd_word & wmask) : '1;

   // ---------------- bus-visible registers ----------------
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < KEY_WORDS; i++)  key_q[i] <= '0;
         for (int unsigned i = 0; i < DATA_WORDS; i++) din_q[i] <= '0;
         encdec_q <= 1'b0;
         irq_en_q <= 1'b0;
      end else if (wr_acc) begin
         for (int unsigned i = 0; i < KEY_WORDS; i++)
            if (off == i) key_q[i] <= (key_q[i] & ~wmask) | (data_from_bus & wmask);
         for (int unsigned i = 0; i < DATA_WORDS; i++)
            if (off == OFF_DIN + i) din_q[i] <= (din_q[i] & ~wmask) | (data_from_bus & wmask);
         if ((off == OFF_CTRL) && byte_sel[0]) begin
            encdec_q <= data_from_bus[1];
            irq_en_q <= data_from_bus[2];
         end
      end
   end

   for (genvar g = 0; g < KEY_WORDS; g++) begin : g_kin
      assign core_kin[32*g +: 32] = key_q[g];
   end
   for (genvar g = 0; g < DATA_WORDS; g++) begin : g_din
      assign core_din[32*g +: 32] = din_q[g];
   end

   assign core_encdec = encdec_q;
   assign core_krdy   = krdy_q;
   assign core_drdy   = drdy_q;
   assign irq         = irq_en_q && (!fifo_empty || terr_q);

   // ---------------- load sequencer with watchdog ----------------
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         krdy_q      <= 1'b0;
         drdy_q      <= 1'b0;
         key_dirty_q <= 1'b1;
         terr_q      <= 1'b0;
         wdog_q      <= '0;
         res_q       <= '0;
      end else begin
         krdy_q <= 1'b0;
         drdy_q <= 1'b0;
         if (clr_acc) terr_q <= 1'b0;
         if (key_wr)  key_dirty_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start_acc) begin
                  if (key_dirty_q) begin
                     state_q <= S_LOAD_KEY;
                     krdy_q  <= 1'b1;
                  end else begin
                     state_q <= S_LOAD_DATA;
                     drdy_q  <= 1'b1;
                  end
               end
            end
            S_LOAD_KEY: begin
               // A key write landing on the load edge was not seen by the core; keep it dirty.
               if (!key_wr) key_dirty_q <= 1'b0;
               wdog_q  <= '0;
               state_q <= S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
               if (core_kvld || (!core_bsy && (wdog_q != '0))) begin
                  state_q <= S_LOAD_DATA;
                  drdy_q  <= 1'b1;
               end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                  terr_q      <= 1'b1;
                  key_dirty_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  wdog_q <= wdog_q + WDW'(1);
               end
            end
            S_LOAD_DATA: begin
               wdog_q  <= '0;
               state_q <= S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               if (core_dvld) begin
                  res_q   <= core_dout;
                  state_q <= S_PUSH;
               end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                  terr_q      <= 1'b1;
                  key_dirty_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  wdog_q <= wdog_q + WDW'(1);
               end
            end
            S_PUSH:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------- result FIFO ----------------
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge wb_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= res_q;
   end

endmodule

// File: tb/tb_cipher_mmio_ctrl.sv
// Scoreboard bench for cipher_mmio_ctrl: expected result blocks are queued at START
// and compared word by word when read back from DOUT.
module tb_cipher_mmio_ctrl;

   localparam int K        = 4;
   localparam int D        = 4;
   localparam int DEPTH    = 4;
   localparam int TMO      = 64;
   localparam int OFF_DIN  = K;
   localparam int OFF_CTRL = K + D;
   localparam int OFF_STAT = K + D + 1;
   localparam int OFF_DOUT = K + D + 2;

   logic            wb_clk = 1'b0;
   logic            reset;
   logic            request, write;
   logic [31:0]     address;
   logic [3:0]      byte_sel;
   logic [31:0]     data_from_bus, data_to_bus;
   logic            done, err;
   logic [32*K-1:0] core_kin;
   logic [32*D-1:0] core_din, core_dout;
   logic            core_encdec, core_krdy, core_drdy;
   logic            core_bsy, core_kvld, core_dvld;
   logic            irq;

   always #5 wb_clk = ~wb_clk;

   cipher_mmio_ctrl #(
      .KEY_WORDS (K),
      .DATA_WORDS(D),
      .BASE      (32'h0),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT   (TMO)
   ) dut (
      .wb_clk       (wb_clk),
      .reset        (reset),
      .request      (request),
      .write        (write),
      .address      (address),
      .byte_sel     (byte_sel),
      .data_from_bus(data_from_bus),
      .data_to_bus  (data_to_bus),
      .done         (done),
      .err          (err),
      .core_kin     (core_kin),
      .core_din     (core_din),
      .core_encdec  (core_encdec),
      .core_krdy    (core_krdy),
      .core_drdy    (core_drdy),
      .core_bsy     (core_bsy),
      .core_kvld    (core_kvld),
      .core_dvld    (core_dvld),
      .core_dout    (core_dout),
      .irq          (irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- core model ----------------
   int              kdelay = 3, ddelay = 10, kcnt, dcnt;
   bit              kact, dact, hang;
   int              nkrdy = 0, ndrdy = 0;
   logic [32*K-1:0] mkey;
   logic [32*D-1:0] mdin;
   logic            menc;

   always @(negedge wb_clk) begin
      core_kvld = 1'b0;
      core_dvld = 1'b0;
      if (reset) begin
         kact = 0; dact = 0; core_bsy = 1'b0;
      end else begin
         if (core_krdy) begin
            nkrdy++; mkey = core_kin; kact = 1; kcnt = kdelay; core_bsy = 1'b1;
         end else if (kact) begin
            kcnt--;
            if (kcnt <= 0) begin kact = 0; core_kvld = 1'b1; core_bsy = 1'b0; end
         end
         if (core_drdy) begin
            ndrdy++; mdin = core_din; menc = core_encdec; dact = 1; dcnt = ddelay; core_bsy = 1'b1;
         end else if (dact && !hang) begin
            dcnt--;
            if (dcnt <= 0) begin
               dact = 0; core_dvld = 1'b1; core_bsy = 1'b0;
               core_dout = mdin ^ mkey ^ {(32*D){menc}};
            end
         end
      end
   end

   // ---------------- register model and scoreboard ----------------
   logic [31:0]     key_m [K];
   logic [31:0]     din_m [D];
   logic            keydirty_m, enc_m, irqen_m;
   logic [32*K-1:0] corekey_m;
   logic [32*D-1:0] sb [$];

   function automatic logic [31:0] wa(input int off);
      return 32'(off) << 2;
   endfunction

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] bs);
      logic [31:0] m;
      m = {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < K; i++) key_m[i] = '0;
      for (int i = 0; i < D; i++) din_m[i] = '0;
      keydirty_m = 1'b1; enc_m = 1'b0; irqen_m = 1'b0; corekey_m = '0;
      sb.delete();
   endtask

   task automatic bus(input logic wr, input logic [31:0] addr, input logic [3:0] bs,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e);
      @(negedge wb_clk);
      request = 1'b1; write = wr; address = addr; byte_sel = bs; data_from_bus = wd;
      #1;
      rd = data_to_bus;
      e  = err;
      @(posedge wb_clk);
      #1;
      request = 1'b0; write = 1'b0;
   endtask

   task automatic wr_reg(input string tag, input int off, input logic [31:0] d, input logic [3:0] bs);
      logic [31:0] r; logic e;
      bus(1'b1, wa(off), bs, d, r, e);
      check_eq(tag, e, 1'b0);
      if (off < K) begin
         key_m[off] = bmerge(key_m[off], d, bs);
         keydirty_m = 1'b1;
      end else if (off < K + D) begin
         din_m[off-K] = bmerge(din_m[off-K], d, bs);
      end
   endtask

   task automatic rd_chk(input string tag, input int off, input logic [3:0] bs, input logic [31:0] exp);
      logic [31:0] r; logic e;
      bus(1'b0, wa(off), bs, 32'h0, r, e);
      check_eq(tag, r, exp);
   endtask

   task automatic do_start(input string tag, input bit expect_ok);
      logic [31:0] r; logic e; logic kd;
      logic [32*D-1:0] dp;
      kd = keydirty_m;
      bus(1'b1, wa(OFF_CTRL), 4'hF, {29'd0, irqen_m, enc_m, 1'b1}, r, e);
      check_eq({tag, "_err"}, e, !expect_ok);
      if (expect_ok) begin
         check_eq({tag, "_krdy"}, core_krdy, kd);
         check_eq({tag, "_drdy"}, core_drdy, !kd);
         if (kd) begin
            for (int i = 0; i < K; i++) corekey_m[32*i +: 32] = key_m[i];
            keydirty_m = 1'b0;
         end
         for (int i = 0; i < D; i++) dp[32*i +: 32] = din_m[i];
         sb.push_back(dp ^ corekey_m ^ {(32*D){enc_m}});
      end
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] r; logic e; int n;
      n = 0;
      do begin
         bus(1'b0, wa(OFF_STAT), 4'hF, 32'h0, r, e);
         n++;
      end while (r[0] && n < 300);
      check_eq({tag, "_idle"}, r[0], 1'b0);
   endtask

   task automatic read_block(input string tag);
      logic [32*D-1:0] exp; logic [31:0] r; logic e;
      check_eq({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      for (int w = 0; w < D; w++) begin
         bus(1'b0, wa(OFF_DOUT + w), 4'hF, 32'h0, r, e);
         check_eq($sformatf("%s_w%0d", tag, w), r, exp[32*w +: 32]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r; logic e; int n, nk0, nd0;
      reset = 1'b1; request = 1'b0; write = 1'b0; address = '0; byte_sel = '0; data_from_bus = '0;
      core_bsy = 1'b0; core_kvld = 1'b0; core_dvld = 1'b0; core_dout = '0; hang = 0;
      model_reset();
      repeat (2) @(posedge wb_clk);
      #1;
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_err", err, 1'b0);
      check_eq("idle_data", data_to_bus, 32'hFFFF_FFFF);
      check_eq("rst_krdy", core_krdy, 1'b0);
      check_eq("rst_drdy", core_drdy, 1'b0);
      check_eq("rst_irq", irq, 1'b0);
      @(negedge wb_clk);
      reset = 1'b0;

      rd_chk("rst_status", OFF_STAT, 4'hF, 32'h0);
      bus(1'b0, 32'h40, 4'hF, 32'h0, r, e);
      check_eq("oor_err", e, 1'b1);
      check_eq("oor_data", r, 32'hFFFF_FFFF);
      rd_chk("dout_empty", OFF_DOUT, 4'hF, 32'h0);
      bus(1'b0, 32'h2, 4'hF, 32'h0, r, e);
      check_eq("misalign_err", e, 1'b1);

      for (int i = 0; i < K; i++) wr_reg("key_wr", i, 32'hC0DE_0000 + 32'(i * 32'h1111), 4'hF);
      for (int i = 0; i < D; i++) wr_reg("din_wr", OFF_DIN + i, 32'h0123_4567 ^ 32'(i << 20), 4'hF);
      wr_reg("key0_bm", 0, 32'hAABB_CCDD, 4'b0101);
      rd_chk("key0_full", 0, 4'hF, key_m[0]);
      rd_chk("key0_lo", 0, 4'b0011, key_m[0] & 32'h0000_FFFF);
      rd_chk("din3", OFF_DIN + 3, 4'hF, din_m[3]);

      // first job with key load
      enc_m = 1'b0; irqen_m = 1'b1; kdelay = 3; ddelay = 10;
      nk0 = nkrdy; nd0 = ndrdy;
      do_start("job1", 1);
      bus(1'b1, wa(OFF_CTRL), 4'hF, 32'h5, r, e);
      check_eq("start_busy_err", e, 1'b1);
      bus(1'b1, wa(OFF_STAT), 4'hF, 32'h0, r, e);
      check_eq("wr_status_err", e, 1'b1);
      wait_idle("job1");
      check_eq("job1_nkrdy", 32'(nkrdy - nk0), 32'd1);
      check_eq("job1_ndrdy", 32'(ndrdy - nd0), 32'd1);
      rd_chk("job1_stat", OFF_STAT, 4'hF, 32'h0000_0100);
      check_eq("job1_irq", irq, 1'b1);
      rd_chk("ctrl_rd", OFF_CTRL, 4'hF, 32'h4);
      read_block("job1");
      rd_chk("job1_stat_pop", OFF_STAT, 4'hF, 32'h0);
      check_eq("job1_irq_clr", irq, 1'b0);

      // second job, key unchanged
      wr_reg("din2", OFF_DIN + 1, 32'hDEAD_BEEF, 4'hF);
      nk0 = nkrdy; nd0 = ndrdy;
      do_start("job2", 1);
      wait_idle("job2");
      check_eq("job2_nkrdy", 32'(nkrdy - nk0), 32'd0);
      check_eq("job2_ndrdy", 32'(ndrdy - nd0), 32'd1);
      read_block("job2");

      // fill the FIFO
      ddelay = 2;
      for (int j = 0; j < DEPTH; j++) begin
         wr_reg("din_fill", OFF_DIN, 32'h5A00_0000 + 32'(j), 4'hF);
         do_start($sformatf("fill%0d", j), 1);
         wait_idle($sformatf("fill%0d", j));
      end
      rd_chk("full_stat", OFF_STAT, 4'hF, 32'h0000_0404);
      bus(1'b1, wa(OFF_CTRL), 4'hF, {29'd0, irqen_m, enc_m, 1'b1}, r, e);
      check_eq("full_start_err", e, 1'b1);
      check_eq("full_no_krdy", core_krdy, 1'b0);
      check_eq("full_no_drdy", core_drdy, 1'b0);
      rd_chk("full_stat2", OFF_STAT, 4'hF, 32'h0000_0404);
      read_block("pop1");
      rd_chk("pop1_stat", OFF_STAT, 4'hF, 32'h0000_0300);
      wr_reg("din_refill", OFF_DIN + 2, 32'h7777_1234, 4'hF);
      do_start("refill", 1);
      wait_idle("refill");
      rd_chk("refill_stat", OFF_STAT, 4'hF, 32'h0000_0404);
      for (int j = 0; j < DEPTH; j++) read_block($sformatf("drain%0d", j));
      rd_chk("drain_stat", OFF_STAT, 4'hF, 32'h0);

      // watchdog on data phase
      hang = 1;
      do_start("tmo", 1);
      void'(sb.pop_back());
      n = 1;
      bus(1'b0, wa(OFF_STAT), 4'hF, 32'h0, r, e);
      while (r[0] && n < TMO + 50) begin
         bus(1'b0, wa(OFF_STAT), 4'hF, 32'h0, r, e);
         n++;
      end
      check_eq("tmo_cycles", 32'(n), 32'(TMO + 2));
      keydirty_m = 1'b1;
      rd_chk("tmo_stat", OFF_STAT, 4'hF, 32'h0000_0002);
      check_eq("tmo_irq", irq, 1'b1);
      bus(1'b1, wa(OFF_CTRL), 4'hF, 32'h8, r, e);
      check_eq("clr_err", e, 1'b0);
      enc_m = 1'b0; irqen_m = 1'b0;
      rd_chk("clr_stat", OFF_STAT, 4'hF, 32'h0);
      rd_chk("clr_ctrl", OFF_CTRL, 4'hF, 32'h0);
      check_eq("clr_irq", irq, 1'b0);

      // recovery reloads the key after a timeout
      hang = 0; enc_m = 1'b1; irqen_m = 1'b1;
      do_start("recov", 1);
      wait_idle("recov");
      check_eq("recov_irq", irq, 1'b1);
      read_block("recov");

      // asynchronous reset mid-operation
      do_start("pre_rst", 1);
      wait_idle("pre_rst");
      ddelay = 10;
      do_start("mid", 1);
      repeat (3) @(posedge wb_clk);
      check_eq("mid_irq_before", irq, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_irq", irq, 1'b0);
      check_eq("mid_rst_drdy", core_drdy, 1'b0);
      rd_chk("mid_rst_stat", OFF_STAT, 4'hF, 32'h0);
      model_reset();
      @(negedge wb_clk);
      reset = 1'b0;
      rd_chk("post_rst_stat", OFF_STAT, 4'hF, 32'h0);
      rd_chk("post_rst_key0", 0, 4'hF, 32'h0);
      rd_chk("post_rst_dout", OFF_DOUT, 4'hF, 32'h0);
      rd_chk("post_rst_ctrl", OFF_CTRL, 4'hF, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
